// File: rtl/register_file.sv
// Architectural register file: 15 write-enabled registers (R0..R14), two
// combinational read ports, one synchronous write port; index 15 reads the PC+8 input.

module register_file_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (en) begin
            val_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;
endmodule

module register_file #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE3,
    input  logic [3:0]       A1,
    input  logic [3:0]       A2,
    input  logic [3:0]       A3,
    input  logic [WIDTH-1:0] WD3,
    input  logic [WIDTH-1:0] R15,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic [7:0]       wr_count
);
    // Entry 15 of the read table is the live PC+8 input, so every 4-bit
    // address resolves to a defined value without an out-of-range index.
    logic [WIDTH-1:0] reg_val [16];
    logic [14:0]      reg_en;
    logic             wr_valid;
    logic             byp_ok;
    logic [WIDTH-1:0] rd1_mux;
    logic [WIDTH-1:0] rd2_mux;
    logic [7:0]       wr_count_q;
    logic [7:0]       wr_count_d;

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_reg
            assign reg_en[gi] = WE3 && (A3 == 4'(gi));
            register_file_reg #(.WIDTH(WIDTH)) u_reg (
                .clk  (clk),
                .srst (reset),
                .en   (reg_en[gi]),
                .d    (WD3),
                .q    (reg_val[gi])
            );
        end
    endgenerate

    assign reg_val[15] = R15;

    always_comb begin
        wr_valid = WE3 && (A3 != 4'hF);
        byp_ok   = (BYPASS != 0) && wr_valid && !reset;
        rd1_mux  = reg_val[A1];
        rd2_mux  = reg_val[A2];
        if (byp_ok && (A1 == A3)) begin
            rd1_mux = WD3;
        end
        if (byp_ok && (A2 == A3)) begin
            rd2_mux = WD3;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_valid) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    // Reset wins over a simultaneous write, so the count never moves on a reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign RD1      = rd1_mux;
    assign RD2      = rd2_mux;
    assign wr_count = wr_count_q;
endmodule
